agnus_blitter_fill_stream: RTL

AGNUS_BLITTER_FILL_STREAM -- requirements
Module: agnus_blitter_fill_stream

---
 rtl/agnus_blitter_pkg.sv | 21 ++
 rtl/agnus_blitter_fill_core.sv | 38 +++
 rtl/agnus_blitter_fill_stream.sv | 79 +++++++
 3 files changed

// File: rtl/agnus_blitter_pkg.sv
// rtl/agnus_blitter_pkg.sv - shared fill-mode type and legal word widths for the blitter fill path
package agnus_blitter_pkg;

  typedef enum logic [1:0] {
    FILL_BYPASS = 2'd0,
    FILL_INCL   = 2'd1,
    FILL_EXCL   = 2'd2
  } fill_mode_t;

  localparam int unsigned LEGAL_W [3] = '{16, 32, 64};

  function automatic logic is_legal_w(input int unsigned w);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (LEGAL_W[i] == w) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/agnus_blitter_fill_core.sv
// rtl/agnus_blitter_fill_core.sv - combinational LSB-to-MSB fill carry chain and mode select
module agnus_blitter_fill_core
  import agnus_blitter_pkg::*;
#(
  parameter int W = 16
) (
  input  logic       cin,
  input  logic [W-1:0] data,
  input  fill_mode_t mode,
  output logic [W-1:0] out,
  output logic       cout
);

  logic [W-1:0] c;

  // Each chain bit is the running parity of cin and all data bits at or below it.
  always_comb begin
    logic carry;
    c     = '0;
    carry = cin;
    for (int j = 0; j < W; j++) begin
      carry = carry ^ data[j];
      c[j]  = carry;
    end
  end

  assign cout = c[W-1];

  always_comb begin
    out = data;
    case (mode)
      FILL_EXCL: out = c;
      FILL_INCL: out = c | data;
      default:   out = data;
    endcase
  end

endmodule

// File: rtl/agnus_blitter_fill_stream.sv
// rtl/agnus_blitter_fill_stream.sv - streaming area-fill stage with line tracking and one-deep output register
module agnus_blitter_fill_stream
  import agnus_blitter_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ife,
  input  logic         efe,
  input  logic         fci,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_sol,
  input  logic         in_eol,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_eol,
  output logic         out_fco,
  output logic         busy
);

  logic         accept;
  logic         line_start;
  logic         line_open;
  logic         carry_q;
  logic         cin;
  logic         cout;
  logic [W-1:0] fill;
  fill_mode_t   pin_mode;
  fill_mode_t   mode_q;
  fill_mode_t   mode_eff;

  // Reset forces ready high but blocks the accept, so nothing slips in during reset.
  assign in_ready   = reset || !out_valid || out_ready;
  assign accept     = in_valid && in_ready && !reset;
  assign line_start = in_sol || !line_open;

  assign pin_mode = efe ? FILL_EXCL : (ife ? FILL_INCL : FILL_BYPASS);
  assign mode_eff = line_start ? pin_mode : mode_q;
  assign cin      = line_start ? fci : carry_q;

  agnus_blitter_fill_core #(.W(W)) u_core (
    .cin  (cin),
    .data (in_data),
    .mode (mode_eff),
    .out  (fill),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
      out_fco   <= 1'b0;
      carry_q   <= 1'b0;
      line_open <= 1'b0;
      mode_q    <= FILL_BYPASS;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= fill;
        out_eol   <= in_eol;
        out_fco   <= cout;
        carry_q   <= cout;
        line_open <= !in_eol;
        mode_q    <= mode_eff;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = line_open || out_valid;

endmodule
